// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the flop-based multi-port FIFO.
//   ptr_add   - modular pointer add for arbitrary (non power-of-two) depth
//   is_thermo - checks that a request vector is thermometer-coded from bit 0
//   cnt_w     - width needed to hold a count of 0..n
package fifo_pkg;

    // Widest request vector the thermometer checker handles.
    localparam int unsigned MAX_LANES = 32;

    // Width of a counter that must represent every value 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // (ptr + inc) mod depth. Callers guarantee ptr < depth and inc <= depth,
    // so a single compare-and-subtract wraps correctly for any depth.
    function automatic int unsigned ptr_add(input int unsigned ptr,
                                            input int unsigned inc,
                                            input int unsigned depth);
        int unsigned sum;
        sum = ptr + inc;
        if (sum >= depth) begin
            sum = sum - depth;
        end
        return sum;
    endfunction

    // True when v is of the form 0...011...1 (including all zeros).
    // Once a zero has been seen, any later one breaks the pattern.
    function automatic logic is_thermo(input logic [MAX_LANES-1:0] v);
        logic seen_zero;
        logic ok;
        seen_zero = 1'b0;
        ok        = 1'b1;
        for (int i = 0; i < int'(MAX_LANES); i++) begin
            if (!v[i]) begin
                seen_zero = 1'b1;
            end else if (seen_zero) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/fifo_thermo_cnt.sv
// fifo_thermo_cnt: popcount of a per-lane request vector plus a flag telling
// whether the vector is a legal thermometer code from lane 0.
module fifo_thermo_cnt
    import fifo_pkg::*;
#(
    parameter int N    = 4,
    parameter int CNTW = cnt_w(N)
) (
    input  logic [N-1:0]    req_i,
    output logic [CNTW-1:0] cnt_o,
    output logic            thermo_o
);

    // Count the set request bits.
    always_comb begin
        cnt_o = '0;
        for (int i = 0; i < N; i++) begin
            cnt_o = cnt_o + CNTW'(req_i[i]);
        end
    end

    assign thermo_o = is_thermo(MAX_LANES'(req_i));

endmodule

// File: rtl/fifo_flopped_nwmr.sv
// fifo_flopped_nwmr: flop-based FIFO with NPUSH write lanes and NPOP read
// lanes and arbitrary DEPTH. Lane i of a push lands at wptr+i, lane j of the
// output shows the j-th oldest entry. Status outputs decode the entry count.
//
// Optional feature macro: FIFO_ERR_CHK_EN
//   defined   - sticky fifo_err {underflow, overflow} port is present.
//   undefined - no fifo_err port.
// Requests that would overrun the free space or the stored entries, or that
// are not thermometer-coded, are dropped as a whole in either build; only the
// reporting of them is optional.
module fifo_flopped_nwmr
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 8,
    parameter int NPUSH  = 4,
    parameter int NPOP   = 2,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NPUSH-1:0]        push,
    input  logic [NPUSH*DWIDTH-1:0] inData,
    input  logic [NPOP-1:0]         pop,
    output logic [NPOP*DWIDTH-1:0]  outData,
    output logic [NPOP-1:0]         out_valid,
    output logic [CW-1:0]           entry_cnt,
    output logic [CW-1:0]           free_cnt,
    output logic                    fifo_full,
    output logic [NPUSH-1:0]        fifo_nleft_to_full,
    output logic                    fifo_empty,
    output logic                    fifo_1left_to_empty,
`ifdef FIFO_ERR_CHK_EN
    output logic                    fifo_idle,
    output logic [1:0]              fifo_err
`else
    output logic                    fifo_idle
`endif
);

    localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PUSH_CW = cnt_w(NPUSH);
    localparam int POP_CW  = cnt_w(NPOP);

    // Storage is intentionally not reset; out_valid gates what is visible.
    logic [DWIDTH-1:0]  mem_q [DEPTH];

    logic [PW-1:0]      wptr_q;
    logic [PW-1:0]      wptr_d;
    logic [PW-1:0]      rptr_q;
    logic [PW-1:0]      rptr_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;

    logic [PUSH_CW-1:0] npush;
    logic [POP_CW-1:0]  npop;
    logic               push_thermo;
    logic               pop_thermo;
    logic               push_legal;
    logic               pop_legal;

    logic [PW-1:0]      waddr [NPUSH];
    logic [PW-1:0]      raddr [NPOP];

    fifo_thermo_cnt #(
        .N    (NPUSH),
        .CNTW (PUSH_CW)
    ) u_push_cnt (
        .req_i    (push),
        .cnt_o    (npush),
        .thermo_o (push_thermo)
    );

    fifo_thermo_cnt #(
        .N    (NPOP),
        .CNTW (POP_CW)
    ) u_pop_cnt (
        .req_i    (pop),
        .cnt_o    (npop),
        .thermo_o (pop_thermo)
    );

    // Status decodes of the registered entry count.
    assign entry_cnt           = cnt_q;
    assign free_cnt            = CW'(DEPTH) - cnt_q;
    assign fifo_full           = (cnt_q == CW'(DEPTH));
    assign fifo_empty          = (cnt_q == '0);
    assign fifo_1left_to_empty = (cnt_q == CW'(1));
    assign fifo_idle           = fifo_empty && (push == '0);

    // Legality uses only the current state: a same-cycle pop never makes
    // room for a push, and a same-cycle push never feeds a pop.
    assign push_legal = push_thermo && (32'(npush) <= 32'(free_cnt));
    assign pop_legal  = pop_thermo  && (32'(npop)  <= 32'(cnt_q));

    // Per-lane write addresses and the "k+1 slots left" decode.
    for (genvar gi = 0; gi < NPUSH; gi++) begin : g_push_lane
        assign waddr[gi]              = PW'(ptr_add(32'(wptr_q), gi, DEPTH));
        assign fifo_nleft_to_full[gi] = (32'(free_cnt) == gi + 1);
    end

    // Per-lane read addresses; an invalid lane is forced to zero.
    for (genvar gi = 0; gi < NPOP; gi++) begin : g_pop_lane
        assign raddr[gi]     = PW'(ptr_add(32'(rptr_q), gi, DEPTH));
        assign out_valid[gi] = (32'(cnt_q) > gi);
        assign outData[gi*DWIDTH +: DWIDTH] =
            out_valid[gi] ? mem_q[raddr[gi]] : '0;
    end

    // Next pointers and count from the accepted push/pop amounts.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_legal) begin
            wptr_d = PW'(ptr_add(32'(wptr_q), 32'(npush), DEPTH));
        end
        if (pop_legal) begin
            rptr_d = PW'(ptr_add(32'(rptr_q), 32'(npop), DEPTH));
        end
        cnt_d = CW'(32'(cnt_q)
                    + (push_legal ? 32'(npush) : 32'd0)
                    - (pop_legal  ? 32'(npop)  : 32'd0));
    end

    // Pointer and count registers; reset overrides any request.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Write accepted lanes into storage; lanes land at consecutive slots.
    always_ff @(posedge clk) begin
        if (!rst && push_legal) begin
            for (int i = 0; i < NPUSH; i++) begin
                if (push[i]) begin
                    mem_q[waddr[i]] <= inData[i*DWIDTH +: DWIDTH];
                end
            end
        end
    end

`ifdef FIFO_ERR_CHK_EN
    logic [1:0] err_q;

    // Sticky error flags: bit 0 overflow (bad push), bit 1 underflow (bad pop).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if ((push != '0) && !push_legal) begin
                err_q[0] <= 1'b1;
            end
            if ((pop != '0) && !pop_legal) begin
                err_q[1] <= 1'b1;
            end
        end
    end

    assign fifo_err = err_q;
`else
    // Without the checker, rejected requests are simply dropped silently.
`endif

endmodule

// File: tb/tb_fifo_flopped_nwmr.sv
// Bench for fifo_flopped_nwmr: one DEPTH=8 instance for directed traffic and
// one DEPTH=6 instance for randomised legal traffic. Pushed data goes into a
// per-instance queue; a monitor per instance pops and compares on each
// accepted read lane. Build with FIFO_ERR_CHK_EN to also exercise fifo_err.
module tb_fifo_flopped_nwmr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    int total = 0;
    int bad   = 0;

    logic [31:0] q8[$];
    logic [31:0] q6[$];
    bit          mon8_en = 1'b1;

    // DEPTH=8 instance
    logic [3:0]   push8;
    logic [127:0] in8;
    logic [1:0]   pop8;
    logic [63:0]  out8;
    logic [1:0]   ov8;
    logic [3:0]   cnt8, free8, nleft8;
    logic         full8, empty8, one8, idle8;
`ifdef FIFO_ERR_CHK_EN
    logic [1:0]   err8, err6;
`endif

    // DEPTH=6 instance
    logic [3:0]   push6;
    logic [127:0] in6;
    logic [1:0]   pop6;
    logic [63:0]  out6;
    logic [1:0]   ov6;
    logic [2:0]   cnt6, free6;
    logic [3:0]   nleft6;
    logic         full6, empty6, one6, idle6;

    fifo_flopped_nwmr #(.DWIDTH(32), .DEPTH(8), .NPUSH(4), .NPOP(2)) u_dut8 (
        .clk                 (clk),
        .rst                 (rst),
        .push                (push8),
        .inData              (in8),
        .pop                 (pop8),
        .outData             (out8),
        .out_valid           (ov8),
        .entry_cnt           (cnt8),
        .free_cnt            (free8),
        .fifo_full           (full8),
        .fifo_nleft_to_full  (nleft8),
        .fifo_empty          (empty8),
        .fifo_1left_to_empty (one8),
`ifdef FIFO_ERR_CHK_EN
        .fifo_idle           (idle8),
        .fifo_err            (err8)
`else
        .fifo_idle           (idle8)
`endif
    );

    fifo_flopped_nwmr #(.DWIDTH(32), .DEPTH(6), .NPUSH(4), .NPOP(2)) u_dut6 (
        .clk                 (clk),
        .rst                 (rst),
        .push                (push6),
        .inData              (in6),
        .pop                 (pop6),
        .outData             (out6),
        .out_valid           (ov6),
        .entry_cnt           (cnt6),
        .free_cnt            (free6),
        .fifo_full           (full6),
        .fifo_nleft_to_full  (nleft6),
        .fifo_empty          (empty6),
        .fifo_1left_to_empty (one6),
`ifdef FIFO_ERR_CHK_EN
        .fifo_idle           (idle6),
        .fifo_err            (err6)
`else
        .fifo_idle           (idle6)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push8(input int n, input logic [31:0] base, input bit track);
        in8 = '0;
        for (int i = 0; i < n; i++) begin
            in8[i*32 +: 32] = base + 32'(i);
            if (track) q8.push_back(base + 32'(i));
        end
        push8 = 4'((1 << n) - 1);
    endtask

    task automatic drive_push6(input int n);
        logic [31:0] d;
        in6 = '0;
        for (int i = 0; i < n; i++) begin
            d = $urandom;
            in6[i*32 +: 32] = d;
            q6.push_back(d);
        end
        push6 = 4'((1 << n) - 1);
    endtask

    // Scoreboard check for every lane the DUT8 consumer takes this cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst && mon8_en) begin
            for (int j = 0; j < 2; j++) begin
                if (pop8[j]) begin
                    if (q8.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb8_lane%0d: got pop with no expected entry", j);
                    end else begin
                        e = q8.pop_front();
                        chk("sb8_valid", 64'(ov8[j]), 64'd1);
                        chk("sb8_data", 64'(out8[j*32 +: 32]), 64'(e));
                    end
                end
            end
        end
    end

    // Scoreboard check for every lane the DUT6 consumer takes this cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            for (int j = 0; j < 2; j++) begin
                if (pop6[j]) begin
                    if (q6.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL sb6_lane%0d: got pop with no expected entry", j);
                    end else begin
                        e = q6.pop_front();
                        chk("sb6_valid", 64'(ov6[j]), 64'd1);
                        chk("sb6_data", 64'(out6[j*32 +: 32]), 64'(e));
                    end
                end
            end
        end
    end

    localparam logic [31:0] A = 32'hA000_0000;
    localparam logic [31:0] B = 32'hB000_0000;

    initial begin
        int m6;
        int np;
        int no;
        int hi;

        rst = 1'b1;
        push8 = '0; in8 = '0; pop8 = '0;
        push6 = '0; in6 = '0; pop6 = '0;
        step();
        step();
        rst = 1'b0;

        // 1. Reset state
        chk("rst_cnt", 64'(cnt8), 64'd0);
        chk("rst_free", 64'(free8), 64'd8);
        chk("rst_empty", 64'(empty8), 64'd1);
        chk("rst_full", 64'(full8), 64'd0);
        chk("rst_idle", 64'(idle8), 64'd1);
        chk("rst_valid", 64'(ov8), 64'd0);
        chk("rst_data", out8, 64'd0);
        chk("rst_nleft", 64'(nleft8), 64'd0);
        chk("rst_one", 64'(one8), 64'd0);
`ifdef FIFO_ERR_CHK_EN
        chk("rst_err", 64'(err8), 64'd0);
`endif
        push8 = 4'b0001;
        #1;
        chk("idle_with_push", 64'(idle8), 64'd0);
        push8 = '0;

        // 2. Push 4 then 2
        drive_push8(4, A, 1'b1);
        step();
        chk("p4_cnt", 64'(cnt8), 64'd4);
        chk("p4_free", 64'(free8), 64'd4);
        chk("p4_nleft", 64'(nleft8), 64'b1000);
        drive_push8(2, A + 32'd4, 1'b1);
        step();
        push8 = '0;
        chk("p6_cnt", 64'(cnt8), 64'd6);
        chk("p6_nleft", 64'(nleft8), 64'b0010);
        chk("p6_valid", 64'(ov8), 64'b11);
        chk("p6_lane0", 64'(out8[31:0]), 64'(A));
        chk("p6_lane1", 64'(out8[63:32]), 64'(A + 32'd1));

        // 3. Pop two, push one, three times
        for (int k = 0; k < 3; k++) begin
            pop8 = 2'b11;
            drive_push8(1, A + 32'd6 + 32'(k), 1'b1);
            step();
            chk("pp_cnt", 64'(cnt8), 64'(5 - k));
            chk("pp_lane0", 64'(out8[31:0]), 64'(A + 32'd2 + 32'(2 * k)));
            chk("pp_lane1", 64'(out8[63:32]), 64'(A + 32'd3 + 32'(2 * k)));
        end
        pop8 = '0;
        push8 = '0;

        // 5. Fill to 8, then push+pop at full
        drive_push8(4, A + 32'd9, 1'b1);
        step();
        drive_push8(1, A + 32'd13, 1'b1);
        step();
        push8 = '0;
        chk("full_cnt", 64'(cnt8), 64'd8);
        chk("full_flag", 64'(full8), 64'd1);
        chk("full_free", 64'(free8), 64'd0);
        chk("full_nleft", 64'(nleft8), 64'd0);
`ifdef FIFO_ERR_CHK_EN
        drive_push8(1, A + 32'd14, 1'b0);
`endif
        pop8 = 2'b01;
        step();
        push8 = '0;
        pop8 = '0;
        chk("ovf_cnt", 64'(cnt8), 64'd7);
        chk("ovf_lane0", 64'(out8[31:0]), 64'(A + 32'd7));
        chk("ovf_nleft", 64'(nleft8), 64'b0001);
`ifdef FIFO_ERR_CHK_EN
        chk("ovf_err", 64'(err8), 64'b01);
        step();
        chk("ovf_err_sticky", 64'(err8), 64'b01);
`endif

        // 6. Reset during traffic with 5 entries
        pop8 = 2'b11;
        step();
        pop8 = '0;
        chk("pre_rst_cnt", 64'(cnt8), 64'd5);
        rst = 1'b1;
        drive_push8(4, B + 32'h100, 1'b0);
        step();
        rst = 1'b0;
        push8 = '0;
        q8.delete();
        chk("mid_rst_cnt", 64'(cnt8), 64'd0);
        chk("mid_rst_empty", 64'(empty8), 64'd1);
        chk("mid_rst_valid", 64'(ov8), 64'd0);
        chk("mid_rst_data", out8, 64'd0);
        chk("mid_rst_free", 64'(free8), 64'd8);
`ifdef FIFO_ERR_CHK_EN
        chk("mid_rst_err", 64'(err8), 64'd0);
`endif
        drive_push8(1, B, 1'b1);
        step();
        push8 = '0;
        chk("one_cnt", 64'(cnt8), 64'd1);
        chk("one_flag", 64'(one8), 64'd1);
        chk("one_valid", 64'(ov8), 64'b01);
        chk("one_lane0", 64'(out8[31:0]), 64'(B));
`ifdef FIFO_ERR_CHK_EN
        // Pop of two with one stored: dropped, underflow flagged
        mon8_en = 1'b0;
        pop8 = 2'b11;
        step();
        pop8 = '0;
        mon8_en = 1'b1;
        chk("udf_cnt", 64'(cnt8), 64'd1);
        chk("udf_err", 64'(err8), 64'b10);
        chk("udf_lane0", 64'(out8[31:0]), 64'(B));
`endif
        pop8 = 2'b01;
        step();
        pop8 = '0;
        chk("drain8_empty", 64'(empty8), 64'd1);

        // 4. DEPTH=6 randomised legal traffic
        m6 = 0;
        for (int c = 0; c < 40; c++) begin
            hi = (6 - m6 < 4) ? 6 - m6 : 4;
            np = int'($urandom_range(hi, 0));
            hi = (m6 < 2) ? m6 : 2;
            no = int'($urandom_range(hi, 0));
            drive_push6(np);
            pop6 = 2'((1 << no) - 1);
            m6 = m6 + np - no;
            step();
            chk("r6_cnt", 64'(cnt6), 64'(m6));
            chk("r6_free", 64'(free6), 64'(6 - m6));
        end
        push6 = '0;
        while (m6 > 0) begin
            no = (m6 < 2) ? m6 : 2;
            pop6 = 2'((1 << no) - 1);
            m6 = m6 - no;
            step();
        end
        pop6 = '0;
        chk("r6_empty", 64'(empty6), 64'd1);
        chk("r6_sb_drained", 64'(q6.size()), 64'd0);

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
